// File: rtl/comparator_pipe_bdeduffy.sv
// comparator_pipe_bdeduffy: two-stage signed/unsigned magnitude comparator with GT streak detector.
// Optional saturating event counters are compiled in with COMPARATOR_STATS_EN.
module comparator_pipe_bdeduffy #(
    parameter int WIDTH      = 8,
    parameter int STREAK_LEN = 4,
    parameter int COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               mode_signed,
    input  logic               in_valid,
    input  logic               clear,
    output logic               aGTb,
    output logic               aGEb,
    output logic               aLTb,
    output logic               aLEb,
    output logic               aEQb,
    output logic               aNEb,
    output logic               out_valid,
    output logic               gt_streak,
    output logic [COUNT_W-1:0] cnt_gt,
    output logic [COUNT_W-1:0] cnt_eq,
    output logic [COUNT_W-1:0] cnt_lt
);
    typedef enum logic [1:0] {IDLE, RUN, HIT} streakState_t;
    logic [WIDTH-1:0] aReg, bReg;
    logic             modeReg, s1Valid, eq, lt;
    logic [7:0]       runLen;
    streakState_t     state;
    assign eq = aReg == bReg;
    assign lt = modeReg ? ($signed(aReg) < $signed(bReg)) : (aReg < bReg);
    assign gt_streak = state == HIT;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1Valid <= 1'b0;
            aReg    <= '0;
            bReg    <= '0;
            modeReg <= 1'b0;
        end else begin
            s1Valid <= in_valid;
            if (in_valid) begin
                aReg    <= a_in;
                bReg    <= b_in;
                modeReg <= mode_signed;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            {aGTb, aGEb, aLTb, aLEb, aEQb, aNEb} <= '0;
        end else begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                aEQb <= eq;
                aNEb <= ~eq;
                aLTb <= lt;
                aLEb <= lt | eq;
                aGTb <= ~lt & ~eq;
                aGEb <= ~lt;
            end
        end
    end
    // Only completed results move the streak; idle cycles leave it untouched
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state  <= IDLE;
            runLen <= '0;
        end else if (out_valid) begin
            case (state)
                IDLE: if (aGTb) begin
                    runLen <= 8'd1;
                    state  <= (STREAK_LEN == 1) ? HIT : RUN;
                end
                RUN: if (aGTb) begin
                    runLen <= runLen + 8'd1;
                    if (runLen + 8'd1 == 8'(STREAK_LEN)) state <= HIT;
                end else begin
                    state  <= IDLE;
                    runLen <= '0;
                end
                HIT: if (!aGTb) begin
                    state  <= IDLE;
                    runLen <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef COMPARATOR_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt_gt <= '0;
            cnt_eq <= '0;
            cnt_lt <= '0;
        end else if (out_valid) begin
            if (aGTb && cnt_gt != '1) cnt_gt <= cnt_gt + COUNT_W'(1);
            if (aEQb && cnt_eq != '1) cnt_eq <= cnt_eq + COUNT_W'(1);
            if (aLTb && cnt_lt != '1) cnt_lt <= cnt_lt + COUNT_W'(1);
        end
    end
`else
    assign cnt_gt = '0;
    assign cnt_eq = '0;
    assign cnt_lt = '0;
`endif
endmodule

// File: tb/tb_comparator_pipe_bdeduffy.sv
// tb_comparator_pipe_bdeduffy: directed plus randomized checks against a cycle-level reference model.
module tb_comparator_pipe_bdeduffy;
    localparam int W  = 8;
    localparam int SL = 4;
    localparam int CW = 4;
`ifdef COMPARATOR_STATS_EN
    localparam bit statsEn = 1'b1;
`else
    localparam bit statsEn = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          reset_n, mode_signed, in_valid, clear;
    logic [W-1:0]  a_in, b_in;
    logic          aGTb, aGEb, aLTb, aLEb, aEQb, aNEb, out_valid, gt_streak;
    logic [CW-1:0] cnt_gt, cnt_eq, cnt_lt;
    int compared = 0, mismatched = 0;
    bit        p1v = 0, expValid = 0;
    logic [5:0] p1Flags = '0, expFlags = '0;
    int streak = 0, cGt = 0, cEq = 0, cLt = 0;

    comparator_pipe_bdeduffy #(.WIDTH(W), .STREAK_LEN(SL), .COUNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
        .mode_signed(mode_signed), .in_valid(in_valid), .clear(clear),
        .aGTb(aGTb), .aGEb(aGEb), .aLTb(aLTb), .aLEb(aLEb), .aEQb(aEQb), .aNEb(aNEb),
        .out_valid(out_valid), .gt_streak(gt_streak),
        .cnt_gt(cnt_gt), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Order {GT,GE,LT,LE,EQ,NE} from plain integer values
    function automatic logic [5:0] relFlags(input logic [W-1:0] a, input logic [W-1:0] b, input bit m);
        int sa = int'(a);
        int sb = int'(b);
        if (m && a[W-1]) sa -= 2**W;
        if (m && b[W-1]) sb -= 2**W;
        return {sa > sb, sa >= sb, sa < sb, sa <= sb, sa == sb, sa != sb};
    endfunction

    task automatic tick(input bit rn, input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit m, input bit clr);
        reset_n = rn; in_valid = iv; a_in = a; b_in = b; mode_signed = m; clear = clr;
        @(posedge clk);
        if (!rn) begin
            p1v = 0; expValid = 0; expFlags = '0;
            streak = 0; cGt = 0; cEq = 0; cLt = 0;
        end else begin
            if (clr) begin
                streak = 0; cGt = 0; cEq = 0; cLt = 0;
            end else if (expValid) begin
                streak = expFlags[5] ? (streak < 1000 ? streak + 1 : streak) : 0;
                if (expFlags[5] && cGt < 2**CW - 1) cGt++;
                if (expFlags[1] && cEq < 2**CW - 1) cEq++;
                if (expFlags[3] && cLt < 2**CW - 1) cLt++;
            end
            if (p1v) expFlags = p1Flags;
            expValid = p1v;
            p1v = iv;
            if (iv) p1Flags = relFlags(a, b, m);
        end
        #1;
        check("flags", 32'({aGTb, aGEb, aLTb, aLEb, aEQb, aNEb}), 32'(expFlags));
        check("out_valid", 32'(out_valid), 32'(expValid));
        check("gt_streak", 32'(gt_streak), 32'(streak >= SL));
        check("cnt_gt", 32'(cnt_gt), statsEn ? 32'(cGt) : 32'd0);
        check("cnt_eq", 32'(cnt_eq), statsEn ? 32'(cEq) : 32'd0);
        check("cnt_lt", 32'(cnt_lt), statsEn ? 32'(cLt) : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, '0, '0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(0, 0, '0, '0, 0, 0);
        tick(1, 1, 8'h80, 8'h7F, 0, 0);
        tick(1, 1, 8'h80, 8'h7F, 1, 0);
        tick(1, 1, 8'h80, 8'h80, 0, 0);
        tick(1, 1, 8'h80, 8'h80, 1, 0);
        tick(1, 1, 8'h00, 8'hFF, 0, 0);
        tick(1, 1, 8'h00, 8'hFF, 1, 0);
        idle(3);
        tick(1, 1, 8'd9, 8'd3, 0, 0);
        tick(1, 1, 8'd9, 8'd3, 0, 0);
        idle(1);
        tick(1, 1, 8'd9, 8'd3, 0, 0);
        tick(1, 1, 8'd9, 8'd3, 0, 0);
        tick(1, 1, 8'd5, 8'd5, 0, 0);
        idle(4);
        for (int i = 0; i < 20; i++) tick(1, 1, 8'd200, 8'd1, 0, 0);
        idle(3);
        tick(1, 1, 8'd7, 8'd2, 0, 0);
        idle(1);
        tick(1, 0, '0, '0, 0, 1);
        idle(2);
        tick(1, 1, 8'd7, 8'd2, 0, 0);
        tick(1, 1, 8'd1, 8'd2, 0, 0);
        tick(0, 0, '0, '0, 0, 0);
        idle(3);
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom % 4 == 0) ? a : W'($urandom);
            tick($urandom_range(0, 49) != 0, $urandom % 4 != 0, a, b, 1'($urandom), $urandom % 25 == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
